fringe_put_scheduler: RTL and testbench
=======================================

FRINGE_PUT_SCHEDULER -- requirements
Module: fringe_put_scheduler

Interface
REQ-001 SHALL have parameter N_CHAN, default 4: number of mission clock channels.
REQ-002 SHALL have parameter DATA_W, default 9: payload width per channel ({valid, data[7:0]}).
REQ-003 SHALL have parameter TIMEOUT, default 255: WAIT-state watchdog limit in clk_i cycles.
REQ-004 SHALL have port clk_i, input, 1: single utility clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port clk_lvl_i, input, N_CHAN: mission clock levels, already synchronous to clk_i.
REQ-007 SHALL have port mask_i, input, N_CHAN: 1 = ignore edges on that channel.
REQ-008 SHALL have port data_i, input, N_CHAN*DATA_W: per-channel payload, channel c at bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port put_busy_i, input, 1: fringe put path busy (put_status).
REQ-010 SHALL have port put_ack_i, input, 1: fringe put completed successfully.
REQ-011 SHALL have port put_req_o, output, 1: one-cycle put launch strobe.
REQ-012 SHALL have port put_chan_o, output, $clog2(N_CHAN): channel (clock name index) of the current put.
REQ-013 SHALL have port put_data_o, output, DATA_W: payload of the current put.
REQ-014 SHALL have port freeze_clk_o, output, N_CHAN: freeze mission clock c while its put is pending.
REQ-015 SHALL have port done_o, output, 1: one-cycle pulse when a put is acknowledged.
REQ-016 SHALL have port overrun_o, output, N_CHAN: sticky flag, new edge while channel already pending.
REQ-017 SHALL have port timeout_o, output, 1: sticky flag, watchdog expired.

Function
REQ-018 SHALL register clk_lvl_i into lvl_q and detect rise[c] = clk_lvl_i[c] & ~lvl_q[c].
REQ-019 SHALL, on rise[c] with mask_i[c]=0 and pending[c]=0, set pending[c] and capture data_i slice c into data_q[c] on the same edge.
REQ-020 SHALL, on rise[c] with pending[c]=1, keep data_q[c] unchanged and set overrun_o[c].
REQ-021 SHALL drive freeze_clk_o = pending combinationally from the register.
REQ-022 SHALL implement FSM IDLE/ISSUE/WAIT; IDLE -> ISSUE when pending != 0 and put_busy_i = 0, latching grant index g.
REQ-023 SHALL select g round-robin: first pending channel after last granted, wrapping N_CHAN-1 -> 0; after reset the search starts at channel 0.
REQ-024 SHALL, in ISSUE, assert put_req_o for exactly one cycle with put_chan_o = g and put_data_o = data_q[g], then go to WAIT.
REQ-025 SHALL hold put_chan_o/put_data_o stable from ISSUE until leaving WAIT.
REQ-026 SHALL, in WAIT on put_ack_i=1, clear pending[g], pulse done_o, and return to IDLE.
REQ-027 SHALL count WAIT cycles (8-bit minimum); when count = TIMEOUT without ack, set timeout_o, clear pending[g], and return to IDLE.
REQ-028 SHALL ignore put_ack_i outside WAIT.
REQ-029 SHALL, when rise[g] and put_ack_i coincide in WAIT, clear then re-set pending[g] (net 1) and capture the new data; overrun_o[g] is not set.
REQ-030 SHALL allow a rise on channel c to pend at cycle t+1 (t = rise cycle); from IDLE, put_req_o rises at t+2 at the earliest.

Reset
REQ-031 SHALL, on rst_i=1 at any time (including mid-WAIT), asynchronously clear lvl_q, pending, data_q, overrun_o, timeout_o, watchdog counter, and grant pointer; set FSM to IDLE; drive put_req_o=0, done_o=0, put_chan_o=0, put_data_o=0, freeze_clk_o=0.

Structure
REQ-032 SHALL place the FSM state enum and the default TIMEOUT constant in shared package shunt_fringe_pkg.
REQ-033 SHALL implement round-robin selection as sub-module fringe_rr_arbiter (request vector, last-grant pointer, grant index, any-valid output).

Verification
REQ-034 SHALL verify single edge: rise ch3 with data_i[3]=9'h1A5 -> put_req_o at t+2, put_chan_o=3, put_data_o=9'h1A5, freeze_clk_o=4'b1000 until ack, then done_o and freeze 0.
REQ-035 SHALL verify simultaneous rises ch0..ch3 -> puts issued in order 0,1,2,3, with freeze bits clearing one per ack.
REQ-036 SHALL verify busy hold-off: put_busy_i=1 for 10 cycles with ch1 pending -> no put_req_o until the cycle after busy drops.
REQ-037 SHALL verify overrun: second rise ch2 before ack -> overrun_o=4'b0100, put_data_o equals the first captured value.
REQ-038 SHALL verify watchdog: no ack with TIMEOUT=16 -> timeout_o=1 after 16 WAIT cycles, pending cleared, next channel serviced.
REQ-039 SHALL verify reset mid-WAIT: rst_i pulse -> all outputs 0 immediately, and the next rise on ch0 is serviced normally.

Source files
------------

// File: rtl/shunt_fringe_pkg.sv
// Shared types and defaults for the fringe put scheduler.
package shunt_fringe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fsm_state_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/fringe_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i (one past the last grant), wrapping.
module fringe_rr_arbiter #(
    parameter int N_CHAN = 4,
    parameter int IDX_W  = $clog2(N_CHAN)
) (
    input  logic [N_CHAN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  grant_o,
    output logic              any_o
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_CHAN)) begin
                pos = pos - (IDX_W+1)'(N_CHAN);
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found   = 1'b1;
                grant_o = pos[IDX_W-1:0];
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fringe_put_scheduler.sv
// Captures mission-clock rising edges per channel, freezes the channel and
// serialises fringe puts round-robin with an ack/watchdog handshake.
module fringe_put_scheduler #(
    parameter int N_CHAN  = 4,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = shunt_fringe_pkg::DEFAULT_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_CHAN-1:0]          clk_lvl_i,
    input  logic [N_CHAN-1:0]          mask_i,
    input  logic [N_CHAN*DATA_W-1:0]   data_i,
    input  logic                       put_busy_i,
    input  logic                       put_ack_i,
    output logic                       put_req_o,
    output logic [$clog2(N_CHAN)-1:0]  put_chan_o,
    output logic [DATA_W-1:0]          put_data_o,
    output logic [N_CHAN-1:0]          freeze_clk_o,
    output logic                       done_o,
    output logic [N_CHAN-1:0]          overrun_o,
    output logic                       timeout_o
);
    import shunt_fringe_pkg::*;

    localparam int CH_W  = $clog2(N_CHAN);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CHAN - 1);

    fsm_state_e          state_q, state_d;
    logic [N_CHAN-1:0]   lvl_q;
    logic [N_CHAN-1:0]   pending_q, pending_d;
    logic [N_CHAN-1:0]   overrun_q, overrun_d;
    logic [N_CHAN-1:0]   rise, clr;
    logic [DATA_W-1:0]   data_q [N_CHAN];
    logic [DATA_W-1:0]   data_d [N_CHAN];
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     arb_grant;
    logic                arb_any;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;

    assign rise = clk_lvl_i & ~lvl_q;

    fringe_rr_arbiter #(
        .N_CHAN (N_CHAN),
        .IDX_W  (CH_W)
    ) u_arb (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    // ptr_q holds the search start (one past the last grant), so zero after reset.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        wcnt_d     = wcnt_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        clr        = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && !put_busy_i) begin
                    state_d    = ST_ISSUE;
                    g_d        = arb_grant;
                    ptr_d      = (arb_grant == CH_LAST) ? '0 : arb_grant + 1'b1;
                    out_data_d = data_q[arb_grant];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end
            ST_WAIT: begin
                if (put_ack_i) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    clr[g_q] = 1'b1;
                end else if (wcnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    clr[g_q]  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rise on a channel being released this cycle re-arms it instead of overrunning.
    always_comb begin
        pending_d = pending_q & ~clr;
        overrun_d = overrun_q;
        data_d    = data_q;
        for (int c = 0; c < N_CHAN; c++) begin
            if (rise[c] && !mask_i[c]) begin
                if (pending_q[c] && !clr[c]) begin
                    overrun_d[c] = 1'b1;
                end else begin
                    pending_d[c] = 1'b1;
                    data_d[c]    = data_i[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lvl_q      <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            out_data_q <= '0;
            g_q        <= '0;
            ptr_q      <= '0;
            wcnt_q     <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            for (int c = 0; c < N_CHAN; c++) begin
                data_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lvl_q      <= clk_lvl_i;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            out_data_q <= out_data_d;
            g_q        <= g_d;
            ptr_q      <= ptr_d;
            wcnt_q     <= wcnt_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            data_q     <= data_d;
        end
    end

    assign put_req_o    = (state_q == ST_ISSUE);
    assign put_chan_o   = g_q;
    assign put_data_o   = out_data_q;
    assign freeze_clk_o = pending_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_fringe_put_scheduler.sv
// Scoreboard bench for fringe_put_scheduler: directed scenarios plus random traffic.
module tb_fringe_put_scheduler;

    localparam int N  = 4;
    localparam int DW = 9;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    clk_lvl_i;
    logic [N-1:0]    mask_i;
    logic [N*DW-1:0] data_i;
    logic            put_busy_i;
    logic            put_ack_i;
    logic            put_req_o;
    logic [1:0]      put_chan_o;
    logic [DW-1:0]   put_data_o;
    logic [N-1:0]    freeze_clk_o;
    logic            done_o;
    logic [N-1:0]    overrun_o;
    logic            timeout_o;

    always #5 clk = ~clk;

    fringe_put_scheduler #(
        .N_CHAN  (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clk_lvl_i    (clk_lvl_i),
        .mask_i       (mask_i),
        .data_i       (data_i),
        .put_busy_i   (put_busy_i),
        .put_ack_i    (put_ack_i),
        .put_req_o    (put_req_o),
        .put_chan_o   (put_chan_o),
        .put_data_o   (put_data_o),
        .freeze_clk_o (freeze_clk_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] dat;
    } put_t;

    // Reference model: pending set, captured payloads, one put in flight at a time.
    bit [N-1:0]    m_pend;
    logic [DW-1:0] m_dat [N];
    bit [N-1:0]    m_prev;
    bit [N-1:0]    m_ovr;
    bit            m_tmo;
    bit            m_done;
    int            m_phase;   // 0 idle, 1 put launched this cycle, 2 awaiting ack
    int            m_cur;
    int            m_waited;
    int            m_start;
    logic [DW-1:0] m_cur_dat;

    put_t exp_put_q [$];
    int   exp_done_q [$];
    int   log_ch [$];

    task automatic model_reset();
        m_pend = '0;
        m_prev = '0;
        m_ovr = '0;
        m_tmo = 1'b0;
        m_done = 1'b0;
        m_phase = 0;
        m_cur = 0;
        m_waited = 0;
        m_start = 0;
        m_cur_dat = '0;
        for (int c = 0; c < N; c++) m_dat[c] = '0;
        exp_put_q.delete();
        exp_done_q.delete();
    endtask

    task automatic model_step();
        bit [N-1:0] old_pend;
        int clear;
        bit found;
        old_pend = m_pend;
        clear = -1;
        m_done = 1'b0;
        case (m_phase)
            0: begin
                if (old_pend != '0 && !put_busy_i) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && old_pend[(m_start + k) % N]) begin
                            found = 1'b1;
                            m_cur = (m_start + k) % N;
                        end
                    end
                    m_start = (m_cur + 1) % N;
                    m_cur_dat = m_dat[m_cur];
                    m_phase = 1;
                    exp_put_q.push_back('{ch: 2'(m_cur), dat: m_cur_dat});
                end
            end
            1: begin
                m_phase = 2;
                m_waited = 0;
            end
            default: begin
                m_waited++;
                if (put_ack_i) begin
                    clear = m_cur;
                    m_done = 1'b1;
                    exp_done_q.push_back(m_cur);
                    m_phase = 0;
                end else if (m_waited == TO) begin
                    clear = m_cur;
                    m_tmo = 1'b1;
                    m_phase = 0;
                end
            end
        endcase
        if (clear >= 0) m_pend[clear] = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (clk_lvl_i[c] && !m_prev[c] && !mask_i[c]) begin
                if (old_pend[c] && c != clear) begin
                    m_ovr[c] = 1'b1;
                end else begin
                    m_pend[c] = 1'b1;
                    m_dat[c] = data_i[c*DW +: DW];
                end
            end
        end
        m_prev = clk_lvl_i;
    endtask

    // Monitor: compares DUT against the model away from the active edge.
    always @(negedge clk) begin
        put_t e;
        int   d;
        checks++;
        if ({put_req_o, done_o, freeze_clk_o, overrun_o, timeout_o} !==
            {m_phase == 1, m_done, m_pend, m_ovr, m_tmo}) begin
            failures++;
            $display("FAIL ctl t=%0t got req=%b done=%b frz=%b ovr=%b tmo=%b expected req=%b done=%b frz=%b ovr=%b tmo=%b",
                     $time, put_req_o, done_o, freeze_clk_o, overrun_o, timeout_o,
                     m_phase == 1, m_done, m_pend, m_ovr, m_tmo);
        end
        if (put_req_o) begin
            checks++;
            if (exp_put_q.size() == 0) begin
                failures++;
                $display("FAIL put_unexpected t=%0t got chan=%0d data=%h expected no put", $time, put_chan_o, put_data_o);
            end else begin
                e = exp_put_q.pop_front();
                if (put_chan_o !== e.ch || put_data_o !== e.dat) begin
                    failures++;
                    $display("FAIL put_payload t=%0t got chan=%0d data=%h expected chan=%0d data=%h",
                             $time, put_chan_o, put_data_o, e.ch, e.dat);
                end
            end
            log_ch.push_back(int'(put_chan_o));
        end
        if (m_phase == 2) begin
            checks++;
            if (put_chan_o !== 2'(m_cur) || put_data_o !== m_cur_dat) begin
                failures++;
                $display("FAIL put_hold t=%0t got chan=%0d data=%h expected chan=%0d data=%h",
                         $time, put_chan_o, put_data_o, m_cur, m_cur_dat);
            end
        end
        if (done_o) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected t=%0t got done=1 expected none", $time);
            end else begin
                d = exp_done_q.pop_front();
                if (put_chan_o !== 2'(d)) begin
                    failures++;
                    $display("FAIL done_chan t=%0t got chan=%0d expected chan=%0d", $time, put_chan_o, d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_i) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] slice(int c, logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        r = '0;
        r[c*DW +: DW] = v;
        return r;
    endfunction

    task automatic pulse_rise(logic [N-1:0] chans, logic [N*DW-1:0] dvec);
        clk_lvl_i = clk_lvl_i & ~chans;
        tick();
        data_i = dvec;
        clk_lvl_i = clk_lvl_i | chans;
        tick();
        clk_lvl_i = clk_lvl_i & ~chans;
    endtask

    task automatic wait_phase(int ph, int budget);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_phase%0d", ph), 32'(m_phase), 32'(ph));
    endtask

    task automatic ack_current(int delay);
        wait_phase(2, 100);
        for (int i = 0; i < delay; i++) tick();
        put_ack_i = 1'b1;
        tick();
        put_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t got running expected finished", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [DW-1:0]  a, b;
        logic [N*DW-1:0] dv;
        int n;
        rst_i = 1'b1;
        clk_lvl_i = '0;
        mask_i = '0;
        data_i = '0;
        put_busy_i = 1'b0;
        put_ack_i = 1'b0;
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("reset_outputs", {put_req_o, done_o, put_chan_o, put_data_o, freeze_clk_o, overrun_o, timeout_o}, '0);

        // Single edge on ch3: launch two cycles after the rise, freeze until ack.
        data_i = slice(3, 9'h1A5);
        clk_lvl_i = 4'b1000;
        tick();
        chk("single_t1_req", put_req_o, 0);
        chk("single_t1_freeze", freeze_clk_o, 4'b1000);
        tick();
        chk("single_t2_req", put_req_o, 1);
        chk("single_chan", put_chan_o, 3);
        chk("single_data", put_data_o, 9'h1A5);
        clk_lvl_i = '0;
        wait_phase(2, 10);
        tick();
        chk("single_freeze_wait", freeze_clk_o, 4'b1000);
        put_ack_i = 1'b1;
        tick();
        put_ack_i = 1'b0;
        chk("single_done", done_o, 1);
        chk("single_freeze_clear", freeze_clk_o, 4'b0000);

        // Simultaneous rises: serviced 0,1,2,3, one freeze bit released per ack.
        log_ch.delete();
        for (int c = 0; c < N; c++) dv[c*DW +: DW] = DW'($urandom);
        pulse_rise(4'b1111, dv);
        for (int k = 0; k < N; k++) begin
            ack_current($urandom_range(0, 4));
            chk("multi_freeze", freeze_clk_o, 32'(4'(4'hF << (k + 1))));
        end
        tick();
        chk("multi_count", 32'(log_ch.size()), 4);
        for (int k = 0; k < N && k < log_ch.size(); k++) chk("multi_order", 32'(log_ch[k]), 32'(k));

        // Busy hold-off on ch1.
        put_busy_i = 1'b1;
        pulse_rise(4'b0010, slice(1, 9'h0C3));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_no_req", put_req_o, 0);
        end
        put_busy_i = 1'b0;
        tick();
        chk("busy_release_req", put_req_o, 1);
        chk("busy_release_chan", put_chan_o, 1);
        ack_current(1);

        // Overrun on ch2: second rise before ack keeps the first payload.
        a = 9'h155;
        b = 9'h0AA;
        pulse_rise(4'b0100, slice(2, a));
        wait_phase(2, 10);
        pulse_rise(4'b0100, slice(2, b));
        chk("overrun_flag", overrun_o, 4'b0100);
        chk("overrun_data", put_data_o, a);
        ack_current(0);

        // Watchdog: ch0 never acked, ch1 follows.
        pulse_rise(4'b0011, slice(0, 9'h111) | slice(1, 9'h122));
        wait_phase(2, 10);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("wdog_not_yet", timeout_o, 0);
        tick();
        chk("wdog_timeout", timeout_o, 1);
        chk("wdog_freeze", freeze_clk_o, 4'b0010);
        tick();
        chk("wdog_next_req", put_req_o, 1);
        chk("wdog_next_chan", put_chan_o, 1);
        chk("wdog_next_data", put_data_o, 9'h122);
        ack_current(2);

        // Asynchronous reset while waiting for an ack.
        pulse_rise(4'b0001, slice(0, 9'h1F0));
        wait_phase(2, 10);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_async_outputs", {put_req_o, done_o, put_chan_o, put_data_o, freeze_clk_o, overrun_o, timeout_o}, '0);
        tick();
        rst_i = 1'b0;
        pulse_rise(4'b0001, slice(0, 9'h07E));
        tick();
        chk("rst_after_req", put_req_o, 1);
        chk("rst_after_chan", put_chan_o, 0);
        chk("rst_after_data", put_data_o, 9'h07E);
        ack_current(1);

        // Random traffic: edges, masks, busy and stray acks.
        for (int i = 0; i < 400; i++) begin
            clk_lvl_i = clk_lvl_i ^ (N'($urandom) & N'($urandom));
            mask_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            for (int c = 0; c < N; c++) data_i[c*DW +: DW] = DW'($urandom);
            put_busy_i = ($urandom_range(0, 4) == 0);
            put_ack_i = ($urandom_range(0, 2) == 0);
            tick();
        end

        // Drain with steady inputs and acks always present.
        mask_i = '0;
        put_busy_i = 1'b0;
        put_ack_i = 1'b1;
        n = 0;
        while ((m_phase != 0 || m_pend != '0) && n < 200) begin
            tick();
            n++;
        end
        put_ack_i = 1'b0;
        tick();
        chk("drain_idle", {30'd0, m_phase != 0, m_pend != '0}, 0);
        chk("drain_puts_left", 32'(exp_put_q.size()), 0);
        chk("drain_dones_left", 32'(exp_done_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
